// File: rtl/weight_fifo_wconv_rewind_if.sv
// Handshake bundle between the DDR weight fetch path (master) and the
// wide-to-narrow weight FIFO (slave).
interface weight_fifo_wconv_rewind_if #(
  parameter int DATA_R  = 64,
  parameter int RATIO   = 2,
  parameter int DEPTH_W = 8
);
  localparam int DATA_W = DATA_R * RATIO;
  localparam int LOG2R  = $clog2(RATIO);

  logic                     i_wren;
  logic [DATA_W-1:0]        i_wrdata;
  logic                     o_full;
  logic                     o_almost_full;
  logic                     i_rden;
  logic [DATA_R-1:0]        o_rddata;
  logic                     o_rdvalid;
  logic                     o_empty;
  logic                     o_almost_empty;
  logic [DEPTH_W+LOG2R:0]   o_rd_count;
  logic                     i_mark;
  logic                     i_rewind;
  logic                     i_release;
  logic                     o_mark_active;
  logic                     o_overflow;
  logic                     o_underflow;

  modport master (
    output i_wren, i_wrdata, i_rden, i_mark, i_rewind, i_release,
    input  o_full, o_almost_full, o_rddata, o_rdvalid, o_empty,
           o_almost_empty, o_rd_count, o_mark_active, o_overflow, o_underflow
  );

  modport slave (
    input  i_wren, i_wrdata, i_rden, i_mark, i_rewind, i_release,
    output o_full, o_almost_full, o_rddata, o_rdvalid, o_empty,
           o_almost_empty, o_rd_count, o_mark_active, o_overflow, o_underflow
  );
endinterface

// File: rtl/weight_fifo_wconv_rewind.sv
// Weight buffer FIFO: wide writes, narrow reads (slice 0 first), with a
// mark/rewind replay point that protects marked words from overwrite.
module weight_fifo_wconv_rewind #(
  parameter int DATA_R                 = 64,
  parameter int RATIO                  = 2,
  parameter int DEPTH_W                = 8,
  parameter int ALMOST_FULL_THRESHOLD  = 189,
  parameter int ALMOST_EMPTY_THRESHOLD = 32
) (
  input  logic                         system_clk,
  input  logic                         rst,
  weight_fifo_wconv_rewind_if.slave    fifo
);
  localparam int DATA_W = DATA_R * RATIO;
  localparam int LOG2R  = $clog2(RATIO);
  localparam int WP     = DEPTH_W + 1;
  localparam int RP     = DEPTH_W + LOG2R + 1;
  localparam int NWORDS = 1 << DEPTH_W;
  localparam logic [31:0] SLICE_BITS = 32'(DATA_R);

  logic [WP-1:0]     wrptr;
  logic [RP-1:0]     rdptr;
  logic [RP-1:0]     markptr;
  logic              mark_active;
  logic              overflow;
  logic              underflow;
  logic              rdvalid;

  logic [RP-1:0]     base;
  logic [WP-1:0]     wr_used;
  logic [RP-1:0]     rd_count;
  logic [RP-1:0]     rdptr_nxt;
  logic              full;
  logic              empty;
  logic              wr_acc;
  logic              rd_acc;

  logic [DATA_W-1:0] mem [NWORDS];
  logic [DATA_W-1:0] rd_word;
  logic [RP-1:0]     rd_slice;
  logic [31:0]       rd_off;

  // Occupancy is measured from the mark while one is held, so the word the
  // mark points into stays allocated even after it has been read past.
  // rd_count uses a shift instead of a zero-width concat so RATIO=1 works.
  always_comb begin
    base      = mark_active ? markptr : rdptr;
    wr_used   = wrptr - base[RP-1:LOG2R];
    rd_count  = (RP'(wrptr) << LOG2R) - rdptr;
    full      = (wr_used == WP'(NWORDS));
    empty     = (rd_count == '0);
    wr_acc    = fifo.i_wren & ~full;
    rd_acc    = fifo.i_rden & ~empty & ~fifo.i_rewind;
    rdptr_nxt = rdptr + RP'(rd_acc);
  end

  always_ff @(posedge system_clk or posedge rst) begin
    if (rst) begin
      wrptr       <= '0;
      rdptr       <= '0;
      markptr     <= '0;
      mark_active <= 1'b0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
      rdvalid     <= 1'b0;
    end else begin
      if (wr_acc)
        wrptr <= wrptr + WP'(1);
      overflow  <= overflow  | (fifo.i_wren & full);
      underflow <= underflow | (fifo.i_rden & empty & ~fifo.i_rewind);
      rdvalid   <= rd_acc;
      // Rewind outranks release and mark; it also suppresses any read.
      if (fifo.i_rewind) begin
        if (mark_active)
          rdptr <= markptr;
      end else begin
        rdptr <= rdptr_nxt;
        if (fifo.i_release) begin
          mark_active <= 1'b0;
        end else if (fifo.i_mark) begin
          markptr     <= rdptr_nxt;
          mark_active <= 1'b1;
        end
      end
    end
  end

  // Storage and read word register carry no reset so they map onto block RAM.
  always_ff @(posedge system_clk) begin
    if (wr_acc)
      mem[wrptr[DEPTH_W-1:0]] <= fifo.i_wrdata;
    if (rd_acc) begin
      rd_word  <= mem[rdptr[LOG2R +: DEPTH_W]];
      rd_slice <= rdptr & RP'(RATIO - 1);
    end
  end

  assign rd_off = 32'(rd_slice) * SLICE_BITS;

  assign fifo.o_rddata       = DATA_R'(rd_word >> rd_off);
  assign fifo.o_rdvalid      = rdvalid;
  assign fifo.o_full         = full;
  assign fifo.o_almost_full  = (wr_used >= WP'(ALMOST_FULL_THRESHOLD));
  assign fifo.o_empty        = empty;
  assign fifo.o_almost_empty = (rd_count < RP'(ALMOST_EMPTY_THRESHOLD));
  assign fifo.o_rd_count     = rd_count;
  assign fifo.o_mark_active  = mark_active;
  assign fifo.o_overflow     = overflow;
  assign fifo.o_underflow    = underflow;
endmodule

// File: tb/tb_weight_fifo_wconv_rewind.sv
// Bench for weight_fifo_wconv_rewind: stream-level reference model checked
// every cycle, plus directed scenarios with hand-computed pin values.
module tb_weight_fifo_wconv_rewind;
  localparam int DR = 64;
  localparam int R  = 2;
  localparam int DW = 8;

  localparam int S_DATA = 0, S_VALID = 1, S_EMPTY = 2, S_COUNT = 3, S_FULL = 4,
                 S_AFULL = 5, S_OVF = 6, S_UDF = 7, S_MARK = 8, S_AEMPTY = 9;

  logic system_clk = 1'b0;
  logic rst = 1'b1;
  always #5 system_clk = ~system_clk;

  weight_fifo_wconv_rewind_if #(.DATA_R(DR), .RATIO(R), .DEPTH_W(DW)) bus ();

  weight_fifo_wconv_rewind #(
    .DATA_R(DR), .RATIO(R), .DEPTH_W(DW),
    .ALMOST_FULL_THRESHOLD(189), .ALMOST_EMPTY_THRESHOLD(32)
  ) dut (
    .system_clk(system_clk),
    .rst(rst),
    .fifo(bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: absolute counts of words written and slices read.
  int          m_wr = 0, m_rd = 0, m_mark = 0;
  bit          m_act = 0, m_ovf = 0, m_udf = 0, e_valid = 0;
  logic [63:0] e_data = '0;
  logic [63:0] stream [$];

  typedef struct {
    string       name;
    int          sel;
    logic [63:0] act;
    logic [63:0] exp;
  } pin_t;
  pin_t pins [$];

  int wr_seq = 0;

  function automatic logic [127:0] wword(input int n);
    logic [127:0] w;
    for (int k = 0; k < R; k++)
      w[k*DR +: DR] = 64'h5A00_0000_0000_0000 + 64'(n * 16 + k);
    return w;
  endfunction

  function automatic logic [63:0] dut_val(input int sel);
    case (sel)
      S_DATA:   return bus.o_rddata;
      S_VALID:  return 64'(bus.o_rdvalid);
      S_EMPTY:  return 64'(bus.o_empty);
      S_COUNT:  return 64'(bus.o_rd_count);
      S_FULL:   return 64'(bus.o_full);
      S_AFULL:  return 64'(bus.o_almost_full);
      S_OVF:    return 64'(bus.o_overflow);
      S_UDF:    return 64'(bus.o_underflow);
      S_MARK:   return 64'(bus.o_mark_active);
      S_AEMPTY: return 64'(bus.o_almost_empty);
      default:  return '0;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_wr = 0; m_rd = 0; m_mark = 0; m_act = 0;
    m_ovf = 0; m_udf = 0; e_valid = 0;
    stream.delete();
  endtask

  task automatic model_update();
    int rdc, used;
    bit mfull, mempty, wa, ra;
    rdc    = m_wr * R - m_rd;
    used   = m_wr - (m_act ? m_mark : m_rd) / R;
    mfull  = (used == (1 << DW));
    mempty = (rdc == 0);
    wa = bus.i_wren && !mfull;
    ra = bus.i_rden && !mempty && !bus.i_rewind;
    if (bus.i_wren && mfull) m_ovf = 1;
    if (bus.i_rden && mempty && !bus.i_rewind) m_udf = 1;
    e_valid = ra;
    if (ra) begin
      e_data = stream[m_rd];
      m_rd++;
    end
    if (wa) begin
      for (int k = 0; k < R; k++) stream.push_back(bus.i_wrdata[k*DR +: DR]);
      m_wr++;
    end
    if (bus.i_rewind) begin
      if (m_act) m_rd = m_mark;
    end else if (bus.i_release) begin
      m_act = 0;
    end else if (bus.i_mark) begin
      m_mark = m_rd;
      m_act  = 1;
    end
  endtask

  task automatic compare_all();
    int rdc, used;
    pin_t p;
    rdc  = m_wr * R - m_rd;
    used = m_wr - (m_act ? m_mark : m_rd) / R;
    chk("rd_count",     64'(bus.o_rd_count),     64'(rdc));
    chk("empty",        64'(bus.o_empty),        64'(rdc == 0));
    chk("almost_empty", 64'(bus.o_almost_empty), 64'(rdc < 32));
    chk("full",         64'(bus.o_full),         64'(used == (1 << DW)));
    chk("almost_full",  64'(bus.o_almost_full),  64'(used >= 189));
    chk("mark_active",  64'(bus.o_mark_active),  64'(m_act));
    chk("overflow",     64'(bus.o_overflow),     64'(m_ovf));
    chk("underflow",    64'(bus.o_underflow),    64'(m_udf));
    chk("rdvalid",      64'(bus.o_rdvalid),      64'(e_valid));
    if (e_valid) chk("rddata", bus.o_rddata, e_data);
    while (pins.size() > 0) begin
      p = pins.pop_front();
      chk(p.name, (p.sel < 0) ? p.act : dut_val(p.sel), p.exp);
    end
  endtask

  // Model advances on each rising edge; outputs compared 2 units after the falling edge.
  initial begin
    forever begin
      @(posedge system_clk);
      if (rst) model_reset(); else model_update();
      @(negedge system_clk);
      #2;
      if (rst) model_reset();
      compare_all();
    end
  end

  task automatic pin(input string nm, input int sel, input logic [63:0] exp);
    pins.push_back('{name: nm, sel: sel, act: '0, exp: exp});
  endtask

  task automatic pin_v(input string nm, input logic [63:0] act, input logic [63:0] exp);
    pins.push_back('{name: nm, sel: -1, act: act, exp: exp});
  endtask

  task automatic step(input bit wr, input bit rd, input bit mk, input bit rw, input bit rl);
    bus.i_wren    = wr;
    bus.i_wrdata  = wword(wr_seq);
    if (wr) wr_seq++;
    bus.i_rden    = rd;
    bus.i_mark    = mk;
    bus.i_rewind  = rw;
    bus.i_release = rl;
    @(negedge system_clk);
  endtask

  task automatic idle();   step(0, 0, 0, 0, 0); endtask
  task automatic wr1();    step(1, 0, 0, 0, 0); endtask
  task automatic rd1();    step(0, 1, 0, 0, 0); endtask

  initial begin
    int cnt, cyc, rdc;
    bit w, r;
    bus.i_wren = 0; bus.i_wrdata = '0; bus.i_rden = 0;
    bus.i_mark = 0; bus.i_rewind = 0; bus.i_release = 0;

    // Reset state
    repeat (2) @(negedge system_clk);
    pin("rst_empty", S_EMPTY, 1);
    pin("rst_aempty", S_AEMPTY, 1);
    pin("rst_count", S_COUNT, 0);
    pin("rst_full", S_FULL, 0);
    pin("rst_valid", S_VALID, 0);
    pin("rst_mark", S_MARK, 0);
    @(negedge system_clk);
    rst = 0;

    // 1: four words in, eight slices out in order
    wr1();
    pin("t1_empty_lat1", S_EMPTY, 0);
    repeat (3) wr1();
    pin("t1_count8", S_COUNT, 8);
    rd1();
    pin("t1_valid", S_VALID, 1);
    pin("t1_d0", S_DATA, 64'h5A00_0000_0000_0000);
    rd1();
    pin("t1_d1", S_DATA, 64'h5A00_0000_0000_0001);
    rd1();
    pin("t1_d2", S_DATA, 64'h5A00_0000_0000_0010);
    repeat (5) rd1();
    pin("t1_empty", S_EMPTY, 1);
    pin("t1_count0", S_COUNT, 0);
    idle();
    pin("t1_novalid", S_VALID, 0);

    // 2: fill to full, almost_full threshold, overflow on 257th
    for (int i = 1; i <= 256; i++) begin
      wr1();
      if (i == 188) pin("t2_afull188", S_AFULL, 0);
      if (i == 189) pin("t2_afull189", S_AFULL, 1);
      if (i == 255) pin("t2_full255", S_FULL, 0);
      if (i == 256) pin("t2_full256", S_FULL, 1);
    end
    wr1();
    pin("t2_ovf", S_OVF, 1);
    pin("t2_count512", S_COUNT, 512);
    repeat (512) rd1();
    pin("t2_drained", S_EMPTY, 1);

    // 3: mark, read 6, rewind (with a colliding read), replay 6
    repeat (10) wr1();
    step(0, 0, 1, 0, 0);
    pin("t3_mark", S_MARK, 1);
    repeat (6) rd1();
    pin("t3_count14", S_COUNT, 14);
    step(0, 1, 0, 1, 0);
    pin("t3_rewind_novalid", S_VALID, 0);
    pin("t3_count20", S_COUNT, 20);
    rd1();
    pin("t3_replay0", S_DATA, 64'h5A00_0000_0000_1050);
    repeat (5) rd1();
    step(0, 0, 0, 0, 1);
    repeat (14) rd1();
    idle();

    // 4: marked data blocks writes until release
    rst = 1; idle(); rst = 0;
    step(0, 0, 1, 0, 0);
    repeat (256) wr1();
    repeat (512) rd1();
    pin("t4_count0", S_COUNT, 0);
    pin("t4_full_marked", S_FULL, 1);
    wr1();
    pin("t4_ovf", S_OVF, 1);
    pin("t4_dropped", S_COUNT, 0);
    step(0, 0, 0, 0, 1);
    pin("t4_released", S_MARK, 0);
    pin("t4_not_full", S_FULL, 0);
    wr1();
    pin("t4_accepted", S_COUNT, 2);
    repeat (2) rd1();

    // 5: 600 interleaved words across pointer wrap
    cnt = 0; cyc = 0;
    while (!(cnt == 600 && (m_wr * R - m_rd) == 0) && cyc < 4000) begin
      rdc = m_wr * R - m_rd;
      w = (cnt < 600) && (rdc < 20) && (cyc % 7 != 3);
      r = ((rdc > 6) && (cyc % 5 != 1)) || (cnt >= 600 && rdc > 0);
      step(w, r, 0, 0, 0);
      if (w) cnt++;
      cyc++;
    end
    pin_v("t5_in_budget", 64'(cyc < 4000), 1);
    idle();

    // 6: reset with data stored and a read in flight
    rd1();
    pin("t6_udf", S_UDF, 1);
    repeat (5) wr1();
    bus.i_rden = 1;
    @(posedge system_clk);
    #1;
    rst = 1;
    bus.i_rden = 0;
    @(negedge system_clk);
    pin("t6_novalid", S_VALID, 0);
    pin("t6_empty", S_EMPTY, 1);
    pin("t6_count0", S_COUNT, 0);
    pin("t6_ovf_clr", S_OVF, 0);
    pin("t6_udf_clr", S_UDF, 0);
    idle();
    rst = 0;
    idle();
    idle();
    #3;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
